// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial two's-complement subtractor, d = a - b - bin.
// One result bit per clock, LSB first, with a single borrow flop carrying
// the borrow between bits. Valid/ready on both sides, one operation in flight.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] d,
    output logic             bout,
    output logic             ovf,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Full-subtractor difference bit.
    function automatic logic fs_diff(input logic x, input logic y, input logic bw);
        return x ^ y ^ bw;
    endfunction

    // Full-subtractor borrow-out.
    function automatic logic fs_borrow(input logic x, input logic y, input logic bw);
        return (~x & y) | (~(x ^ y) & bw);
    endfunction

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_d;
    logic [CW-1:0]    r_cnt;
    logic             r_borrow;
    logic             r_a_msb;
    logic             r_b_msb;
    logic             r_bout;
    logic             r_ovf;

    logic             w_diff;
    logic             w_borrow_nxt;
    logic [WIDTH-1:0] w_d_nxt;
    logic             w_ovf_nxt;

    // Current bit-slice of the subtraction, from the low bits of the operand shifters.
    always_comb begin
        w_diff       = fs_diff(r_a[0], r_b[0], r_borrow);
        w_borrow_nxt = fs_borrow(r_a[0], r_b[0], r_borrow);
        // The final diff bit becomes d[MSB], so overflow can be decided on the last edge.
        w_ovf_nxt    = (r_a_msb != r_b_msb) && (w_diff != r_a_msb);
    end

    // The new diff bit enters the result at the MSB end; a 1-bit result is just the bit.
    generate
        if (WIDTH == 1) begin : g_d_narrow
            assign w_d_nxt = w_diff;
        end else begin : g_d_wide
            assign w_d_nxt = {w_diff, r_d[WIDTH-1:1]};
        end
    endgenerate

    // Control FSM and datapath: accept in IDLE, shift one bit per edge in RUN, hold in DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_a      <= {WIDTH{1'b0}};
            r_b      <= {WIDTH{1'b0}};
            r_d      <= {WIDTH{1'b0}};
            r_cnt    <= {CW{1'b0}};
            r_borrow <= 1'b0;
            r_a_msb  <= 1'b0;
            r_b_msb  <= 1'b0;
            r_bout   <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a      <= a;
                        r_b      <= b;
                        r_borrow <= bin;
                        r_a_msb  <= a[WIDTH-1];
                        r_b_msb  <= b[WIDTH-1];
                        r_cnt    <= {CW{1'b0}};
                        r_state  <= S_RUN;
                    end else begin
                        r_state  <= S_IDLE;
                    end
                end
                S_RUN: begin
                    r_d      <= w_d_nxt;
                    r_a      <= r_a >> 1;
                    r_b      <= r_b >> 1;
                    r_borrow <= w_borrow_nxt;
                    r_cnt    <= r_cnt + CW'(1);
                    if (r_cnt == LAST_BIT) begin
                        r_bout  <= w_borrow_nxt;
                        r_ovf   <= w_ovf_nxt;
                        r_state <= S_DONE;
                    end else begin
                        r_state <= S_RUN;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_state <= S_DONE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Handshake flags decode from the state register only; results come straight from flops.
    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign busy      = (r_state == S_RUN) || (r_state == S_DONE);
    assign d         = r_d;
    assign bout      = r_bout;
    assign ovf       = r_ovf;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH = 8): directed corner
// cases plus randomized operations against an arithmetic reference model.
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] d;
    logic         bout;
    logic         ovf;
    logic         busy;

    int n_vec = 0;
    int n_err = 0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .d         (d),
        .bout      (bout),
        .ovf       (ovf),
        .busy      (busy)
    );

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer subtraction; overflow by the sign-bit rule on the operands and result.
    task automatic ref_model(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tbin,
                             output logic [W-1:0] ed, output logic eb, output logic eo);
        int diff;
        diff = int'(ta) - int'(tb_v) - int'(tbin);
        ed   = diff[W-1:0];
        eb   = (diff < 0);
        eo   = (ta[W-1] != tb_v[W-1]) && (ed[W-1] != ta[W-1]);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete operation: accept, latency, result, optional backpressure and a busy-time poke.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tbin,
                          input int hold, input bit poke);
        logic [W-1:0] ed;
        logic         eb;
        logic         eo;
        int           lat;
        ref_model(ta, tb_v, tbin, ed, eb, eo);

        lat = 0;
        while (!in_ready && lat < 50) begin
            tick();
            lat++;
        end
        check_val("in_ready_idle", {31'd0, in_ready}, 32'd1);

        a = ta; b = tb_v; bin = tbin; in_valid = 1'b1;
        tick();                                   // accept edge
        in_valid = 1'b0;
        a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
        check_val("busy_run", {31'd0, busy}, 32'd1);
        check_val("in_ready_run", {31'd0, in_ready}, 32'd0);

        lat = 0;
        while (!out_valid && lat < 20) begin
            if (poke && lat == 2) begin
                in_valid = 1'b1; a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
                check_val("in_ready_poke", {31'd0, in_ready}, 32'd0);
            end
            if (poke && lat == 4) in_valid = 1'b0;
            tick();
            lat++;
        end
        in_valid = 1'b0;
        check_val("latency", lat, W);
        check_val("d", {24'd0, d}, {24'd0, ed});
        check_val("bout", {31'd0, bout}, {31'd0, eb});
        check_val("ovf", {31'd0, ovf}, {31'd0, eo});

        for (int h = 0; h < hold; h++) begin
            tick();
            check_val("bp_valid", {31'd0, out_valid}, 32'd1);
            check_val("bp_d", {24'd0, d}, {24'd0, ed});
            check_val("bp_flags", {30'd0, bout, ovf}, {30'd0, eb, eo});
        end

        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_val("hs_valid_low", {31'd0, out_valid}, 32'd0);
        check_val("hs_busy_low", {31'd0, busy}, 32'd0);
        check_val("hs_in_ready", {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        int seen;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; bin = 1'b0;

        // Reset held with random inputs toggling.
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'($urandom); out_ready = 1'($urandom);
            a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
            tick();
            check_val("rst_outputs", {21'd0, out_valid, busy, d, bout, ovf},
                      {21'd0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0});
        end
        in_valid = 1'b0; out_ready = 1'b0;
        rst_n = 1'b1;
        #1;
        check_val("rst_in_ready", {31'd0, in_ready}, 32'd1);

        // Directed cases.
        run_op(8'h5A, 8'h3C, 1'b0, 0, 1'b0);
        run_op(8'h00, 8'h01, 1'b0, 0, 1'b0);
        run_op(8'h10, 8'h10, 1'b1, 0, 1'b0);
        run_op(8'h80, 8'h01, 1'b0, 0, 1'b0);
        run_op(8'h7F, 8'hFF, 1'b0, 0, 1'b0);
        run_op(8'h80, 8'h00, 1'b1, 0, 1'b0);
        run_op(8'hC3, 8'h2D, 1'b1, 5, 1'b1);     // backpressure plus busy poke

        // Reset in the middle of RUN.
        a = 8'hAA; b = 8'h55; bin = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick(); tick(); tick();
        rst_n = 1'b0;
        #1;
        check_val("midrst_state", {29'd0, out_valid, busy, in_ready}, {29'd0, 1'b0, 1'b0, 1'b1});
        tick();
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (out_valid) seen++;
        end
        check_val("midrst_no_valid", seen, 0);
        run_op(8'h03, 8'h05, 1'b0, 0, 1'b0);

        // Randomized operations.
        for (int i = 0; i < 40; i++) begin
            run_op(W'($urandom), W'($urandom), 1'($urandom), $urandom_range(0, 3), 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial two's-complement subtractor. Computes d = a - b - bin over WIDTH cycles, one bit per cycle, LSB first.
- A single registered borrow flop carries the borrow between bits; this is the sequential counterpart of the combinational ripple adder chain.
- Sits in area-constrained datapaths where a WIDTH-bit parallel subtractor is not justified.
- Valid/ready handshake on both input and output; one operation in flight at a time.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range WIDTH >= 1.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand set presented.
- in_ready  output  1  block can accept operands; high only in IDLE.
- a  input  WIDTH  minuend.
- b  input  WIDTH  subtrahend.
- bin  input  1  borrow-in.
- out_valid  output  1  result available; high only in DONE.
- out_ready  input  1  consumer accepts result.
- d  output  WIDTH  difference a - b - bin, modulo 2^WIDTH.
- bout  output  1  borrow-out; 1 iff unsigned a < b + bin.
- ovf  output  1  signed overflow: a[MSB] != b[MSB] and d[MSB] != a[MSB].
- busy  output  1  high in RUN or DONE.

Behaviour:
- Reset (async assert, any state):
  - state = IDLE; bit counter, borrow flop, operand shift registers, d, bout, ovf all = 0.
  - out_valid = 0, busy = 0, in_ready = 1 once rst_n is deasserted.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready = 1.
  - On a rising edge with in_valid = 1 (the accept edge): capture a and b into shift registers, capture bin into the borrow flop, latch a[MSB] and b[MSB] for the ovf computation, clear the counter, go to RUN.
  - a, b and bin are sampled only at the accept edge; later changes on those inputs are ignored.
- RUN, each edge:
  - diff bit = a0 ^ b0 ^ borrow.
  - next borrow = (~a0 & b0) | (~(a0 ^ b0) & borrow).
  - Shift the diff bit into the result register at the MSB end; shift both operand registers right by one.
  - counter++.
  - On the edge that processes bit WIDTH-1: go to DONE, load bout = final borrow, load ovf from the latched MSBs and the final d[MSB].
- Latency: out_valid rises exactly WIDTH edges after the accept edge.
- DONE:
  - out_valid = 1; d, bout and ovf are held stable while out_ready = 0 (no limit on backpressure).
  - On an edge with out_ready = 1: go to IDLE, out_valid = 0.
  - d, bout and ovf keep their last values after leaving DONE; consumers must not sample them while out_valid = 0.
- Throughput: no overlap. Earliest next accept is the cycle after the output handshake, so minimum period is WIDTH + 2 cycles.
- in_valid while busy: ignored because in_ready = 0; the upstream producer must hold its data until in_ready = 1.
- out_ready outside DONE: ignored.
- Reset asserted mid-RUN or mid-DONE: operation is discarded immediately; no out_valid pulse follows reset release.
- WIDTH = 1: RUN lasts a single cycle; ovf = (a != b) and (d != a).
- Counter width is $clog2(WIDTH+1).
- No combinational path from any input to any output. in_ready, out_valid and busy decode from the state register only.

Test Plan (WIDTH = 8):
- Reset: hold rst_n = 0 with random inputs -> out_valid = 0, busy = 0, d = 0x00, bout = 0, ovf = 0; after release, in_ready = 1.
- Basic subtract: a = 0x5A, b = 0x3C, bin = 0, accepted at edge T -> out_valid = 1 from edge T+8, d = 0x1E, bout = 0, ovf = 0.
- Underflow and borrow-in:
  - a = 0x00, b = 0x01, bin = 0 -> d = 0xFF, bout = 1, ovf = 0.
  - a = 0x10, b = 0x10, bin = 1 -> d = 0xFF, bout = 1, ovf = 0.
- Signed overflow: a = 0x80, b = 0x01, bin = 0 -> d = 0x7F, bout = 0, ovf = 1; a = 0x7F, b = 0xFF -> d = 0x80, bout = 1, ovf = 1.
- Backpressure and busy input:
  - Hold out_ready = 0 for 5 cycles in DONE -> d, bout and ovf stable, out_valid stays 1.
  - Pulse in_valid with new operands during RUN -> in_ready = 0 and the result is unaffected.
  - Assert out_ready -> IDLE next edge; the next accept is possible on the following edge.
- Reset mid-operation: accept a = 0xAA, b = 0x55, assert rst_n = 0 after 3 RUN edges -> immediate IDLE, out_valid never rises. A subsequent a = 0x03, b = 0x05 gives d = 0xFE, bout = 1, with correct latency.
